// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It consumes one input bit per clock and feeds the 7-segment decoders
//   downstream. Every result nibble is guaranteed to be in 0..9. A value that
//   does not fit in DIGITS decimal digits sets overflow, and the output
//   saturates to all nines.
//
// Parameters
//   BIN_W   width of the binary input (4..32)
//   DIGITS  number of BCD digits produced (1..8)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while idle
//   bin       unsigned binary value, sampled on the accepting edge
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd_out/overflow update
//   bcd_out   packed BCD result, digit i in bits [4i+3:4i]
//   overflow  result exceeded 10^DIGITS-1; held until the next done
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // Adds 3 to every digit that is >= 5. All digits are evaluated in parallel
    // from their pre-shift values.
    function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Saturation pattern: every digit set to 9.
    function automatic logic [SW-1:0] all_nines();
        logic [SW-1:0] r;
        r = {SW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    logic [0:0]       r_state;
    logic [BIN_W-1:0] r_shift;
    logic [SW-1:0]    r_scratch;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [SW-1:0]    r_bcd;
    logic             r_overflow;

    logic [SW-1:0]    w_corr;
    logic [SW-1:0]    w_scratch_nxt;
    logic [BIN_W-1:0] w_shift_nxt;
    logic             w_ovf_nxt;
    logic             w_last;

    // One double-dabble iteration: correct, then shift {scratch, shift} left.
    // The bit leaving the top digit means the value has outgrown DIGITS
    // digits, so it is folded into the sticky overflow.
    always_comb begin
        w_corr        = add3_digits(r_scratch);
        w_scratch_nxt = {w_corr[SW-2:0], r_shift[BIN_W-1]};
        w_shift_nxt   = {r_shift[BIN_W-2:0], 1'b0};
        w_ovf_nxt     = r_ovf | w_corr[SW-1];
        w_last        = (r_cnt == CW'(1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= {BIN_W{1'b0}};
            r_scratch  <= {SW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= {SW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= {SW{1'b0}};
                        r_ovf     <= 1'b0;
                        r_cnt     <= CW'(BIN_W);
                        r_busy    <= 1'b1;
                        r_state   <= ST_CONV;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_shift   <= w_shift_nxt;
                    r_scratch <= w_scratch_nxt;
                    r_ovf     <= w_ovf_nxt;
                    r_cnt     <= r_cnt - CW'(1);
                    if (w_last) begin
                        // Publish the result on the same edge as the last shift.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= w_ovf_nxt;
                        r_bcd      <= w_ovf_nxt ? all_nines() : w_scratch_nxt;
                    end else begin
                        r_done     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4). Expected
//   results come from a decimal reference model. They are queued when a
//   conversion is started and popped when done is seen.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [16:0] exp_q[$];

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: {overflow, bcd} computed with decimal arithmetic.
    function automatic logic [16:0] ref_model(input int unsigned v);
        logic [15:0] b;
        int unsigned t;
        if (v > 9999) return {1'b1, 16'h9999};
        t = v;
        b = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, b};
    endfunction

    // Call at a negedge with the DUT idle. It returns at the next negedge,
    // just after the accepting edge.
    task automatic start_conv(input logic [13:0] v);
        start = 1'b1;
        bin   = v;
        exp_q.push_back(ref_model(32'(v)));
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
    endtask

    // Counts edges since acceptance until done is seen, bounded at 40.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 14'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, overflow, bcd_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, overflow, bcd_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [13:0] vals [2];
        logic [16:0] expd;
        int e, b;
        vals[0] = 14'd0;
        vals[1] = 14'd1234;
        for (int i = 0; i < 2; i++) begin
            start_conv(vals[i]);
            wait_done(e, b);
            expd = exp_q.pop_front();
            checks++;
            if ({overflow, bcd_out} !== expd || done !== 1'b1) begin
                errors++;
                $display("FAIL basic_result bin=%0d got ovf=%b bcd=%h done=%b want ovf=%b bcd=%h",
                         vals[i], overflow, bcd_out, done, expd[16], expd[15:0]);
            end
            checks++;
            if (e != 14 || b != 14) begin
                errors++;
                $display("FAIL basic_timing bin=%0d got latency=%0d busy=%0d want 14/14",
                         vals[i], e, b);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got done=%b one cycle later want 0", done);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [13:0] vals [3];
        logic [16:0] expd;
        int e, b;
        vals[0] = 14'd9999;
        vals[1] = 14'd10000;
        vals[2] = 14'd16383;
        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i]);
            wait_done(e, b);
            expd = exp_q.pop_front();
            checks++;
            if ({overflow, bcd_out} !== expd || done !== 1'b1) begin
                errors++;
                $display("FAIL boundary bin=%0d got ovf=%b bcd=%h done=%b want ovf=%b bcd=%h",
                         vals[i], overflow, bcd_out, done, expd[16], expd[15:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [16:0] expd;
        int e, b, pulses;
        start_conv(14'd42);
        repeat (5) @(negedge clk);
        start = 1'b1;
        bin   = 14'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done(e, b);
        expd = exp_q.pop_front();
        checks++;
        if ({overflow, bcd_out} !== expd || e + 6 != 14) begin
            errors++;
            $display("FAIL ignore_start got ovf=%b bcd=%h latency=%0d want ovf=%b bcd=%h latency=14",
                     overflow, bcd_out, e + 6, expd[16], expd[15:0]);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bcd_out !== 16'h0042) begin
            errors++;
            $display("FAIL ignore_extra_done got pulses=%0d bcd=%h want 0 and 0042", pulses, bcd_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] expd;
        int e, b, t1, t2;
        start_conv(14'd5);
        wait_done(e, b);
        t1 = cyc;
        expd = exp_q.pop_front();
        checks++;
        if ({overflow, bcd_out} !== expd) begin
            errors++;
            $display("FAIL b2b_first got ovf=%b bcd=%h want ovf=%b bcd=%h",
                     overflow, bcd_out, expd[16], expd[15:0]);
        end
        start_conv(14'd9001);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy);
        end
        wait_done(e, b);
        t2 = cyc;
        expd = exp_q.pop_front();
        checks++;
        if ({overflow, bcd_out} !== expd || t2 - t1 != 15) begin
            errors++;
            $display("FAIL b2b_second got ovf=%b bcd=%h spacing=%0d want ovf=%b bcd=%h spacing=15",
                     overflow, bcd_out, t2 - t1, expd[16], expd[15:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        int pulses;
        start_conv(14'd8765);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow, bcd_out} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, overflow, bcd_out);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0 || bcd_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort got pulses=%0d busy=%b bcd=%h want 0/0/0000",
                     pulses, busy, bcd_out);
        end
    endtask

    task automatic test_random_sweep();
        logic [13:0] v;
        logic [16:0] expd;
        int e, b, bad_nib;
        for (int n = 0; n < 30; n++) begin
            v = 14'($urandom_range(0, 16383));
            start_conv(v);
            wait_done(e, b);
            expd = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
            checks++;
            if ({overflow, bcd_out} !== expd || e != 14 || done !== 1'b1) begin
                errors++;
                $display("FAIL random bin=%0d got ovf=%b bcd=%h latency=%0d want ovf=%b bcd=%h latency=14",
                         v, overflow, bcd_out, e, expd[16], expd[15:0]);
            end
            bad_nib = 0;
            for (int i = 0; i < 4; i++) begin
                if (bcd_out[4*i +: 4] > 4'd9) bad_nib++;
            end
            checks++;
            if (bad_nib != 0) begin
                errors++;
                $display("FAIL nibble_range bin=%0d got bcd=%h want every digit <= 9", v, bcd_out);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_conv();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
